// File: rtl/uart_pkg.sv
// Shared UART constants: default clocking, oversampling ratio, divider helper.
package uart_pkg;

   localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;
   localparam int unsigned BAUD_DEFAULT     = 115_200;
   localparam int unsigned OVERSAMPLE       = 8;

   // Clocks per 8x tick, truncated; 0 flags an unusable baud rate.
   function automatic int unsigned div8_calc(input int unsigned clk_freq,
                                             input int unsigned freq);
      if (freq == 0) begin
         return 0;
      end
      return clk_freq / (OVERSAMPLE * freq);
   endfunction

endpackage

// File: rtl/baud_gen_tick_divider.sv
// Modulo-N counter with synchronous clear, advance enable and a registered wrap pulse.
module tick_divider #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic adv_i,
   output logic last_c_o,
   output logic wrap_o
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         wrap_q;
   logic         wrap_d;

   // Advancing out of the terminal count; feeds the next stage and the wrap pulse.
   assign last_c_o = adv_i && (cnt_q == LAST);

   // Next count and wrap pulse; clear dominates and kills any pending pulse.
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (adv_i) begin
         wrap_d = last_c_o;
         cnt_d  = last_c_o ? '0 : cnt_q + W'(1);
      end
   end

   // Counter and pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign wrap_o = wrap_q;

endmodule

// File: rtl/baud_gen.sv
// Baud tick generator: registered 8x-oversample and 1x baud enable pulses.
module baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned freq     = BAUD_DEFAULT,
   parameter int unsigned clk_freq = CLK_FREQ_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic baud_en,
   output logic count_8x_ready,
   output logic count_baud_ready
);

   localparam int unsigned DIV8  = div8_calc(clk_freq, freq);
   localparam int unsigned CW    = (DIV8 < 2) ? 1 : $clog2(DIV8);
   localparam int unsigned SUB_W = $clog2(OVERSAMPLE);

   // Reject baud rates the divider cannot realise.
   if (freq == 0 || DIV8 < 2) begin : g_bad_param
      $error("baud_gen: unusable freq/clk_freq combination, DIV8=%0d", DIV8);
   end

   logic clear;
   logic last8_c;
   logic last_baud_c;
   logic tick8_q;
   logic tick_baud_q;

   // Dropping the enable holds both stages at phase zero.
   assign clear = !baud_en;

   // 8x stage: one wrap every DIV8 enabled clocks.
   tick_divider #(
      .N (DIV8),
      .W (CW)
   ) u_div8 (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (clear),
      .adv_i    (baud_en),
      .last_c_o (last8_c),
      .wrap_o   (tick8_q)
   );

   // Baud stage: counts 8x wraps, wrapping on every eighth one.
   tick_divider #(
      .N (OVERSAMPLE),
      .W (SUB_W)
   ) u_sub (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (clear),
      .adv_i    (last8_c),
      .last_c_o (last_baud_c),
      .wrap_o   (tick_baud_q)
   );

   assign count_8x_ready   = tick8_q;
   assign count_baud_ready = tick_baud_q;

endmodule

// File: tb/tb_baud_gen.sv
// Bench for baud_gen: default divider (108) and a 16 MHz / 9600 instance (208).
module tb_baud_gen;

   localparam int unsigned D1 = 108;   // 100e6 / (8*115200), truncated
   localparam int unsigned D2 = 208;   // 16e6 / (8*9600), truncated

   logic clk = 1'b0;
   logic rst;
   logic baud_en;
   logic a_8x, a_bd, b_8x, b_bd;

   int checks   = 0;
   int failures = 0;

   // Model: enabled edges since last clear, and expected outputs.
   int   m_n = 0;
   logic e_a8 = 1'b0, e_abd = 1'b0, e_b8 = 1'b0, e_bbd = 1'b0;

   always #5 clk = ~clk;

   baud_gen u_a (
      .clk              (clk),
      .rst              (rst),
      .baud_en          (baud_en),
      .count_8x_ready   (a_8x),
      .count_baud_ready (a_bd)
   );

   baud_gen #(
      .freq     (9600),
      .clk_freq (16_000_000)
   ) u_b (
      .clk              (clk),
      .rst              (rst),
      .baud_en          (baud_en),
      .count_8x_ready   (b_8x),
      .count_baud_ready (b_bd)
   );

   task automatic check(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   // Expected outputs: pulse after every multiple of the period in enabled edges.
   always @(posedge clk or posedge rst) begin
      if (rst || !baud_en) begin
         m_n   <= 0;
         e_a8  <= 1'b0;
         e_abd <= 1'b0;
         e_b8  <= 1'b0;
         e_bbd <= 1'b0;
      end else begin
         m_n   <= m_n + 1;
         e_a8  <= ((m_n + 1) % D1) == 0;
         e_abd <= ((m_n + 1) % (8 * D1)) == 0;
         e_b8  <= ((m_n + 1) % D2) == 0;
         e_bbd <= ((m_n + 1) % (8 * D2)) == 0;
      end
   end

   // Continuous comparison on the falling edge.
   always @(negedge clk) begin
      check("model_a_8x",   a_8x, e_a8);
      check("model_a_baud", a_bd, e_abd);
      check("model_b_8x",   b_8x, e_b8);
      check("model_b_baud", b_bd, e_bbd);
   end

   initial begin
      int n_a8, n_abd, n_b8, n_bbd;
      rst     = 1'b1;
      baud_en = 1'b0;

      // Reset and idle while disabled.
      @(negedge clk);
      check("rst_a_8x", a_8x, 1'b0);
      check("rst_a_baud", a_bd, 1'b0);
      rst = 1'b0;
      n_a8 = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n_a8 += int'(a_8x) + int'(a_bd) + int'(b_8x) + int'(b_bd);
      end
      check_int("idle_pulses", n_a8, 0);

      // Enabled window of 1100 clocks.
      baud_en = 1'b1;
      n_a8 = 0; n_abd = 0; n_b8 = 0; n_bbd = 0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge clk);
         n_a8  += int'(a_8x);
         n_abd += int'(a_bd);
         n_b8  += int'(b_8x);
         n_bbd += int'(b_bd);
         if (i == 107) check("a_8x_before_first", a_8x, 1'b0);
         if (i == 108) check("a_8x_first", a_8x, 1'b1);
         if (i == 109) check("a_8x_after_first", a_8x, 1'b0);
         if (i == 216) check("a_8x_second", a_8x, 1'b1);
         if (i == 863) check("a_baud_before_first", a_bd, 1'b0);
         if (i == 864) begin
            check("a_baud_first", a_bd, 1'b1);
            check("a_8x_with_baud", a_8x, 1'b1);
         end
         if (i == 208) check("b_8x_first", b_8x, 1'b1);
      end
      check_int("a_8x_count_1100", n_a8, 10);
      check_int("a_baud_count_1100", n_abd, 1);
      check_int("b_8x_count_1100", n_b8, 5);
      check_int("b_baud_count_1100", n_bbd, 0);

      // Disable for 20 clocks.
      baud_en = 1'b0;
      n_a8 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_a8 += int'(a_8x) + int'(a_bd) + int'(b_8x) + int'(b_bd);
      end
      check_int("disabled_pulses", n_a8, 0);

      // Re-enable: phase restarts from zero.
      baud_en = 1'b1;
      for (int i = 1; i <= 108; i++) begin
         @(negedge clk);
         if (i == 107) check("reen_a_8x_before", a_8x, 1'b0);
      end
      check("reen_a_8x_first", a_8x, 1'b1);

      // Asynchronous reset while a pulse is high.
      #2 rst = 1'b1;
      #1 check("async_rst_clears_8x", a_8x, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-count at phase 50.
      for (int i = 0; i < 50; i++) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("midcount_rst_8x", a_8x, 1'b0);
      check("midcount_rst_baud", a_bd, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Long run from phase zero; covers the 9600-baud period.
      n_abd = 0; n_bbd = 0;
      for (int i = 1; i <= 3400; i++) begin
         @(negedge clk);
         n_abd += int'(a_bd);
         n_bbd += int'(b_bd);
         if (i == 107)  check("post_rst_a_8x_before", a_8x, 1'b0);
         if (i == 108)  check("post_rst_a_8x_first", a_8x, 1'b1);
         if (i == 1728) check("a_baud_second", a_bd, 1'b1);
         if (i == 1456) check("b_8x_seventh", b_8x, 1'b1);
         if (i == 1663) check("b_baud_before_first", b_bd, 1'b0);
         if (i == 1664) check("b_baud_first", b_bd, 1'b1);
         if (i == 3328) check("b_baud_second", b_bd, 1'b1);
      end
      check_int("a_baud_count_3400", n_abd, 3);
      check_int("b_baud_count_3400", n_bbd, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
